inst_fetch_ctrl: RTL and testbench

//   Consumer side of the program-counter interface: takes the fetch address driven by the PC register,

---
 rtl/inst_fetch_ctrl_pkg.sv | 23 ++
 rtl/inst_fetch_ctrl_timeout.sv | 26 ++
 rtl/inst_fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package inst_fetch_ctrl_pkg;

  localparam int REG_W = 32;

  typedef logic [REG_W-1:0] reg_bus_t;
  typedef logic [REG_W-1:0] inst_addr_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2,
    FETCH_HOLD    = 2'd3
  } fetch_state_e;

  // Memory is word addressed; the low two PC bits never reach the bus.
  function automatic inst_addr_bus_t word_align(input inst_addr_bus_t a);
    return a & ~inst_addr_bus_t'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_timeout.sv
// Acknowledge-wait counter: counts cycles while enabled, clears on request,
// flags expiry on the last permitted wait cycle.
module if_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_cnt;

  // wait-cycle counter, clear has priority over count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues the PC to instruction memory over a
// req/ack handshake, returns instruction + PC to IF/ID, stalls the pipeline
// while a fetch is outstanding and drains fetches killed by a flush.
// Optional macro IF_ADEL_EN: misaligned PC raises an address-error exception
// instead of issuing a fetch.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int       ACK_TIMEOUT = 16,
  parameter reg_bus_t NOP_INST    = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  inst_addr_bus_t pc_i,
  input  logic           stall,
  input  logic           flush,
  output logic           inst_req,
  output inst_addr_bus_t inst_addr,
  input  logic           inst_ack,
  input  reg_bus_t       inst_rdata,
  output reg_bus_t       inst_o,
  output inst_addr_bus_t inst_pc_o,
  output logic           inst_valid_o,
  output logic           stall_req_o,
  output logic           bus_err_o,
  output logic           excep_adel_o
);

  fetch_state_e   r_state, w_state_nxt;
  logic           r_req, w_req_nxt;
  inst_addr_bus_t r_addr, w_addr_nxt;
  reg_bus_t       r_inst, w_inst_nxt;
  inst_addr_bus_t r_pc, w_pc_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_err, w_err_nxt;
  logic           w_waiting, w_tmo_en, w_tmo_clr, w_expire;
`ifdef IF_ADEL_EN
  logic           r_adel, w_adel_set, w_adel_nxt;
`endif

  // A request counts as waiting in REQ and DISCARD until acknowledged.
  assign w_waiting = (r_state == FETCH_REQ) || (r_state == FETCH_DISCARD);
  assign w_tmo_en  = w_waiting && !inst_ack;
  assign w_tmo_clr = !w_tmo_en || w_expire;

  if_timeout_cnt #(.LIMIT(ACK_TIMEOUT)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and next output-register values
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_inst_nxt  = r_inst;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_err_nxt   = 1'b0;
`ifdef IF_ADEL_EN
    w_adel_set  = 1'b0;
`endif
    case (r_state)
      FETCH_IDLE: begin
        w_valid_nxt = 1'b0;
        if (!flush && !stall) begin
`ifdef IF_ADEL_EN
          if (pc_i[1:0] != 2'b00) begin
            w_valid_nxt = 1'b1;
            w_inst_nxt  = NOP_INST;
            w_pc_nxt    = pc_i;
            w_adel_set  = 1'b1;
          end else begin
            w_addr_nxt  = word_align(pc_i);
            w_req_nxt   = 1'b1;
            w_state_nxt = FETCH_REQ;
          end
`else
          w_addr_nxt  = word_align(pc_i);
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH_REQ;
`endif
        end
      end
      FETCH_REQ: begin
        if (inst_ack) begin
          w_req_nxt = 1'b0;
          if (!flush) begin
            w_inst_nxt  = inst_rdata;
            w_pc_nxt    = r_addr;
            w_valid_nxt = 1'b1;
            w_state_nxt = stall ? FETCH_HOLD : FETCH_IDLE;
          end else begin
            w_state_nxt = FETCH_IDLE;
          end
        end else if (w_expire) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = FETCH_IDLE;
        end else if (flush) begin
          // request already on the bus: keep it up until memory answers
          w_state_nxt = FETCH_DISCARD;
        end
      end
      FETCH_DISCARD: begin
        // a timeout here is silent: the fetch was already dead
        if (inst_ack || w_expire) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = FETCH_IDLE;
        end
      end
      FETCH_HOLD: begin
        if (flush || !stall) w_state_nxt = FETCH_IDLE;
      end
      default: w_state_nxt = FETCH_IDLE;
    endcase
    // flush kills whatever is being presented, whatever the state
    if (flush) begin
      w_valid_nxt = 1'b0;
      w_inst_nxt  = NOP_INST;
    end
`ifdef IF_ADEL_EN
    w_adel_nxt = w_adel_set || (r_adel && w_valid_nxt);
`endif
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_addr  <= ZERO_WORD;
      r_inst  <= NOP_INST;
      r_pc    <= ZERO_WORD;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_inst  <= w_inst_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef IF_ADEL_EN
  // address-error flag lives as long as the NOP it accompanies
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_adel <= 1'b0;
    else     r_adel <= w_adel_nxt;
  end
  assign excep_adel_o = r_adel;
`else
  assign excep_adel_o = 1'b0;
`endif

  assign inst_req     = r_req;
  assign inst_addr    = r_addr;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_pc;
  assign inst_valid_o = r_valid;
  assign bus_err_o    = r_err;
  assign stall_req_o  = w_waiting && !inst_ack;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: transaction-level model compared every
// cycle, plus hand-computed expectations for each scenario.
module tb_inst_fetch_ctrl;

  localparam int          TO  = 16;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk, rst, stall, flush, inst_ack;
  logic [31:0] pc_i, inst_rdata;
  logic        inst_req, inst_valid_o, stall_req_o, bus_err_o, excep_adel_o;
  logic [31:0] inst_addr, inst_o, inst_pc_o;

  int n_chk  = 0;
  int n_pass = 0;

  inst_fetch_ctrl #(.ACK_TIMEOUT(TO), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_ack     (inst_ack),
    .inst_rdata   (inst_rdata),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .stall_req_o  (stall_req_o),
    .bus_err_o    (bus_err_o),
    .excep_adel_o (excep_adel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Model: one outstanding fetch, optionally marked dropped by a flush,
  // a wait-cycle count, and a "held by stall" flag for the captured word.
  logic        m_req, m_valid, m_err, m_drop, m_hold, m_adel;
  logic [31:0] m_addr, m_inst, m_pc;
  int          m_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 0; m_valid = 0; m_err = 0; m_drop = 0; m_hold = 0; m_adel = 0;
      m_addr = 0; m_inst = NOP; m_pc = 0; m_wait = 0;
    end else begin
      m_err = 0;
      if (m_req) begin
        if (inst_ack) begin
          m_req = 0;
          if (!m_drop && !flush) begin
            m_inst = inst_rdata; m_pc = m_addr; m_valid = 1; m_hold = stall;
          end
          m_drop = 0; m_wait = 0;
        end else if (m_wait == TO - 1) begin
          m_req = 0; m_err = !m_drop; m_drop = 0; m_wait = 0;
        end else begin
          m_wait++;
          if (flush) m_drop = 1;
        end
      end else if (m_hold) begin
        if (flush || !stall) m_hold = 0;
      end else begin
        m_valid = 0;
        if (!flush && !stall) begin
`ifdef IF_ADEL_EN
          if (pc_i[1:0] != 2'b00) begin
            m_valid = 1; m_inst = NOP; m_pc = pc_i; m_adel = 1;
          end else begin
            m_req = 1; m_addr = {pc_i[31:2], 2'b00}; m_wait = 0;
          end
`else
          m_req = 1; m_addr = {pc_i[31:2], 2'b00}; m_wait = 0;
`endif
        end
      end
      if (flush) begin m_valid = 0; m_inst = NOP; end
      m_adel = m_adel && m_valid;
    end
  end

  // every-cycle comparison against the model, after the edge settles
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("m_req",      32'(inst_req),     32'(m_req));
      chk("m_addr",     inst_addr,         m_addr);
      chk("m_inst",     inst_o,            m_inst);
      chk("m_pc",       inst_pc_o,         m_pc);
      chk("m_valid",    32'(inst_valid_o), 32'(m_valid));
      chk("m_bus_err",  32'(bus_err_o),    32'(m_err));
      chk("m_stall_req",32'(stall_req_o),  32'(m_req && !inst_ack));
      chk("m_adel",     32'(excep_adel_o), 32'(m_adel));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nreq, nerr;
    rst = 1; pc_i = 0; stall = 1; flush = 0; inst_ack = 0; inst_rdata = 0;
    tick(); tick();
    chk("rst_req",   32'(inst_req),     0);
    chk("rst_addr",  inst_addr,         0);
    chk("rst_inst",  inst_o,            NOP);
    chk("rst_pc",    inst_pc_o,         0);
    chk("rst_valid", 32'(inst_valid_o), 0);
    chk("rst_err",   32'(bus_err_o),    0);
    chk("rst_adel",  32'(excep_adel_o), 0);
    rst = 0;
    tick();

    // zero-wait fetch
    pc_i = 32'h100; stall = 0;
    tick();
    chk("zw_req", 32'(inst_req), 1);
    chk("zw_addr", inst_addr, 32'h100);
    chk("zw_stall_req", 32'(stall_req_o), 1);
    inst_ack = 1; inst_rdata = 32'h2402_0005;
    #1 chk("zw_stall_req_ack", 32'(stall_req_o), 0);
    tick();
    chk("zw_valid", 32'(inst_valid_o), 1);
    chk("zw_inst", inst_o, 32'h2402_0005);
    chk("zw_pc", inst_pc_o, 32'h100);
    chk("zw_req_drop", 32'(inst_req), 0);
    inst_ack = 0; stall = 1;
    tick();
    chk("zw_valid_clr", 32'(inst_valid_o), 0);

    // three wait cycles, address held while pc_i moves
    pc_i = 32'h104; stall = 0;
    tick();
    pc_i = 32'h200;
    for (int i = 0; i < 3; i++) begin
      chk("w3_stall_req", 32'(stall_req_o), 1);
      chk("w3_addr", inst_addr, 32'h104);
      if (i != 2) tick();
    end
    inst_ack = 1; inst_rdata = 32'h8c22_0000;
    tick();
    chk("w3_valid", 32'(inst_valid_o), 1);
    chk("w3_pc", inst_pc_o, 32'h104);
    chk("w3_inst", inst_o, 32'h8c22_0000);
    inst_ack = 0; stall = 1;
    tick();

    // flush at wait 1, ack two cycles later
    pc_i = 32'h108; stall = 0;
    tick();
    chk("fl_req", 32'(inst_req), 1);
    stall = 1;
    tick();
    flush = 1;
    tick();
    flush = 0;
    chk("fl_req_held", 32'(inst_req), 1);
    chk("fl_valid", 32'(inst_valid_o), 0);
    chk("fl_stall_req", 32'(stall_req_o), 1);
    tick();
    inst_ack = 1; inst_rdata = 32'hdead_beef;
    tick();
    inst_ack = 0;
    chk("fl_req_done", 32'(inst_req), 0);
    chk("fl_valid_after", 32'(inst_valid_o), 0);
    chk("fl_inst_nop", inst_o, NOP);
    tick();

    // stall on ack -> hold, then flush in hold
    pc_i = 32'h10c; stall = 0;
    tick();
    inst_ack = 1; inst_rdata = 32'h1111_2222; stall = 1;
    tick();
    inst_ack = 0; pc_i = 32'h300;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hd_valid", 32'(inst_valid_o), 1);
      chk("hd_inst", inst_o, 32'h1111_2222);
      chk("hd_pc", inst_pc_o, 32'h10c);
    end
    flush = 1;
    tick();
    flush = 0;
    chk("hd_flush_valid", 32'(inst_valid_o), 0);
    chk("hd_flush_inst", inst_o, NOP);
    tick();

    // hold released by stall dropping
    pc_i = 32'h110; stall = 0;
    tick();
    inst_ack = 1; inst_rdata = 32'h3333_4444; stall = 1;
    tick();
    inst_ack = 0;
    tick();
    chk("hr_inst", inst_o, 32'h3333_4444);
    chk("hr_pc", inst_pc_o, 32'h110);
    stall = 0;
    tick();
    stall = 1;
    tick();
    chk("hr_valid_clr", 32'(inst_valid_o), 0);
    chk("hr_no_req", 32'(inst_req), 0);

    // flush and ack in the same cycle
    pc_i = 32'h130; stall = 0;
    tick();
    flush = 1; inst_ack = 1; inst_rdata = 32'h0000_0077;
    tick();
    flush = 0; inst_ack = 0; stall = 1;
    chk("fa_req", 32'(inst_req), 0);
    chk("fa_valid", 32'(inst_valid_o), 0);
    tick();

    // no ack: timeout
    pc_i = 32'h120; stall = 0;
    tick();
    stall = 1;
    nreq = 0; nerr = 0;
    for (int i = 0; i < 30; i++) begin
      if (inst_req) nreq++;
      if (bus_err_o) nerr++;
      tick();
    end
    chk("tmo_req_cycles", nreq, 16);
    chk("tmo_err_pulses", nerr, 1);

    // misaligned pc
    pc_i = 32'h102; stall = 0;
    tick();
`ifdef IF_ADEL_EN
    chk("ad_no_req", 32'(inst_req), 0);
    chk("ad_valid", 32'(inst_valid_o), 1);
    chk("ad_adel", 32'(excep_adel_o), 1);
    chk("ad_pc", inst_pc_o, 32'h102);
    chk("ad_inst", inst_o, NOP);
    stall = 1;
    tick();
    chk("ad_adel_clr", 32'(excep_adel_o), 0);
`else
    chk("ma_addr", inst_addr, 32'h100);
    chk("ma_adel", 32'(excep_adel_o), 0);
    inst_ack = 1; inst_rdata = 32'h0000_0055;
    tick();
    chk("ma_pc", inst_pc_o, 32'h100);
    inst_ack = 0; stall = 1;
    tick();
`endif

    // reset during an outstanding request
    pc_i = 32'h140; stall = 0;
    tick();
    chk("rr_req", 32'(inst_req), 1);
    rst = 1;
    #1;
    chk("rr_req_drop", 32'(inst_req), 0);
    chk("rr_stall_req", 32'(stall_req_o), 0);
    stall = 1;
    tick();
    rst = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
